// File: rtl/snes_controller_emulator.sv
// SNES controller responder: answers an external poller's latch/clk with a 12-button
// snapshot on an active-low serial line, with abort, timeout and frame accounting.
module snes_controller_emulator #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        i_clk_50,
   input  logic        i_reset,
   input  logic        i_controller_latch,
   input  logic        i_controller_clk,
   input  logic [11:0] i_buttons,
   output logic        o_controller_dout,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic [15:0] o_poll_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_latch_sync;
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic                   r_latch_d;
   logic                   r_clk_d;
   logic                   r_latch_rise;
   logic                   r_latch_fall;
   logic                   r_clk_rise;
   logic                   w_latch_s;
   logic                   w_clk_s;
   logic [15:0]            w_snap;

   state_t                 r_state;
   logic [15:0]            r_shreg;
   logic                   r_dout;
   logic                   r_busy;
   logic                   r_frame_done;
   logic [15:0]            r_poll_count;
   logic [TW-1:0]          r_timer;
   logic [4:0]             r_bit_idx;

   assign w_latch_s = r_latch_sync[SYNC_STAGES-1];
   assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
   // Line levels: upper four ID bits always read released, buttons inverted to active-low.
   assign w_snap    = {4'b1111, ~i_buttons};

   // Synchronizers plus registered edge pulses; the clk chain resets high to match its idle level.
   always_ff @(posedge i_clk_50 or posedge i_reset) begin
      if (i_reset) begin
         r_latch_sync <= '0;
         r_clk_sync   <= '1;
         r_latch_d    <= 1'b0;
         r_clk_d      <= 1'b1;
         r_latch_rise <= 1'b0;
         r_latch_fall <= 1'b0;
         r_clk_rise   <= 1'b0;
      end else begin
         r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_controller_latch};
         r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_controller_clk};
         r_latch_d    <= w_latch_s;
         r_clk_d      <= w_clk_s;
         r_latch_rise <= w_latch_s & ~r_latch_d;
         r_latch_fall <= ~w_latch_s & r_latch_d;
         r_clk_rise   <= w_clk_s & ~r_clk_d;
      end
   end

   // Protocol state machine with registered serial data, status and frame counter.
   always_ff @(posedge i_clk_50 or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_shreg      <= 16'hFFFF;
         r_dout       <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_poll_count <= 16'd0;
         r_timer      <= '0;
         r_bit_idx    <= 5'd0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_timer   <= '0;
               r_bit_idx <= 5'd0;
               if (r_latch_d) begin
                  r_state <= ST_LOAD;
                  r_busy  <= 1'b1;
                  r_shreg <= w_snap;
                  r_dout  <= w_snap[0];
               end else begin
                  r_busy  <= 1'b0;
                  r_shreg <= 16'hFFFF;
                  r_dout  <= 1'b1;
               end
            end
            ST_LOAD: begin
               r_shreg <= w_snap;
               r_dout  <= w_snap[0];
               r_busy  <= 1'b1;
               if (r_latch_fall) begin
                  r_state   <= ST_SHIFT;
                  r_bit_idx <= 5'd0;
                  r_timer   <= '0;
               end else begin
                  r_state   <= ST_LOAD;
               end
            end
            ST_SHIFT: begin
               // Priority: latch re-assert, then clk edge, then timeout.
               if (r_latch_rise) begin
                  r_state   <= ST_LOAD;
                  r_shreg   <= w_snap;
                  r_dout    <= w_snap[0];
                  r_timer   <= '0;
                  r_bit_idx <= 5'd0;
               end else if (r_clk_rise) begin
                  r_timer <= '0;
                  if (r_bit_idx == 5'd15) begin
                     r_state      <= ST_IDLE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_poll_count <= r_poll_count + 16'd1;
                     r_bit_idx    <= 5'd0;
                     r_shreg      <= 16'hFFFF;
                     r_dout       <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 5'd1;
                     r_shreg   <= {1'b1, r_shreg[15:1]};
                     r_dout    <= r_shreg[1];
                  end
               end else if (r_timer == TIMER_LAST) begin
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
                  r_timer   <= '0;
                  r_bit_idx <= 5'd0;
                  r_shreg   <= 16'hFFFF;
                  r_dout    <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_shreg <= 16'hFFFF;
               r_dout  <= 1'b1;
            end
         endcase
      end
   end

   assign o_controller_dout = r_dout;
   assign o_busy            = r_busy;
   assign o_frame_done      = r_frame_done;
   assign o_poll_count      = r_poll_count;

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Directed bench for snes_controller_emulator: polls like an external SNES poller and
// scoreboards the serial bits, frame pulses, counter, abort, timeout and reset behaviour.
module tb_snes_controller_emulator;

   localparam int TIMEOUT = 1000;
   localparam int HALF    = 10;

   logic        clk_50 = 1'b0;
   logic        rst = 1'b1;
   logic        latch = 1'b0;
   logic        ctrl_clk = 1'b1;
   logic [11:0] buttons = 12'h000;
   logic        dout;
   logic        busy;
   logic        frame_done;
   logic [15:0] poll_count;

   int   checks = 0;
   int   errors = 0;
   int   fd_count = 0;
   int   fd0;
   logic exp_q[$];

   snes_controller_emulator #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .i_clk_50          (clk_50),
      .i_reset           (rst),
      .i_controller_latch(latch),
      .i_controller_clk  (ctrl_clk),
      .i_buttons         (buttons),
      .o_controller_dout (dout),
      .o_busy            (busy),
      .o_frame_done      (frame_done),
      .o_poll_count      (poll_count)
   );

   always #10 clk_50 = ~clk_50;

   always @(posedge clk_50) if (frame_done === 1'b1) fd_count <= fd_count + 1;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_50);
      #2;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One poll: expected line levels are queued from the snapshot, popped at each falling clk.
   task automatic poll(input string name, input logic [11:0] b, input int nedges,
                       input int change_at, input logic [11:0] nb);
      logic exp_bit;
      buttons = b;
      for (int i = 0; i < 16; i++) exp_q.push_back((i < 12) ? ~b[i] : 1'b1);
      cyc(HALF);
      latch = 1'b1;
      cyc(2 * HALF);
      latch = 1'b0;
      cyc(HALF);
      for (int e = 0; e < nedges; e++) begin
         ctrl_clk = 1'b0;
         exp_bit = exp_q.pop_front();
         check($sformatf("%s_bit%0d", name, e), {15'd0, dout}, {15'd0, exp_bit});
         cyc(HALF);
         ctrl_clk = 1'b1;
         if (e + 1 == change_at) buttons = nb;
         cyc(HALF);
      end
      cyc(HALF);
   endtask

   initial begin
      cyc(5);
      check("rst_dout", {15'd0, dout}, 16'd1);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_fd", {15'd0, frame_done}, 16'd0);
      check("rst_count", poll_count, 16'd0);
      rst = 1'b0;
      cyc(5);

      fd0 = fd_count;
      poll("bonly", 12'h001, 16, -1, 12'h000);
      check("bonly_fd", 16'(fd_count - fd0), 16'd1);
      check("bonly_count", poll_count, 16'd1);
      check("bonly_busy", {15'd0, busy}, 16'd0);

      // Extra clk pulse while idle must not disturb anything.
      ctrl_clk = 1'b0; cyc(HALF); ctrl_clk = 1'b1; cyc(HALF);
      check("idle_edge_dout", {15'd0, dout}, 16'd1);
      check("idle_edge_busy", {15'd0, busy}, 16'd0);
      check("idle_edge_count", poll_count, 16'd1);

      poll("mixed", 12'h108, 16, -1, 12'h000);
      check("mixed_count", poll_count, 16'd2);

      poll("midchg", 12'h0A5, 16, 5, 12'hFFF);
      check("midchg_count", poll_count, 16'd3);
      poll("allpress", 12'hFFF, 16, -1, 12'h000);
      check("allpress_count", poll_count, 16'd4);

      fd0 = fd_count;
      poll("abort", 12'h3C3, 7, -1, 12'h000);
      exp_q.delete();
      latch = 1'b1;
      cyc(2 * HALF);
      check("abort_busy", {15'd0, busy}, 16'd1);
      check("abort_load_dout", {15'd0, dout}, 16'd0);
      check("abort_count", poll_count, 16'd4);
      check("abort_fd", 16'(fd_count - fd0), 16'd0);
      latch = 1'b0;
      cyc(HALF);
      check("shift_wait_busy", {15'd0, busy}, 16'd1);
      cyc(TIMEOUT + TIMEOUT / 10);
      check("timeout_busy", {15'd0, busy}, 16'd0);
      check("timeout_dout", {15'd0, dout}, 16'd1);
      check("timeout_count", poll_count, 16'd4);
      check("timeout_fd", 16'(fd_count - fd0), 16'd0);

      force dut.r_poll_count = 16'hFFFF;
      cyc(1);
      release dut.r_poll_count;
      cyc(1);
      check("preload_count", poll_count, 16'hFFFF);
      fd0 = fd_count;
      poll("wrap", 12'h800, 16, -1, 12'h000);
      check("wrap_count", poll_count, 16'd0);
      check("wrap_fd", 16'(fd_count - fd0), 16'd1);

      poll("partial", 12'hFFF, 3, -1, 12'h000);
      exp_q.delete();
      check("partial_busy", {15'd0, busy}, 16'd1);
      check("partial_dout", {15'd0, dout}, 16'd0);
      @(posedge clk_50);
      #5;
      rst = 1'b1;
      #1;
      check("async_rst_dout", {15'd0, dout}, 16'd1);
      check("async_rst_busy", {15'd0, busy}, 16'd0);
      check("async_rst_count", poll_count, 16'd0);
      cyc(3);
      rst = 1'b0;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snes_controller_emulator.md
# snes_controller_emulator

Responder end of the SNES controller serial protocol. It presents a 12-button snapshot on `controller_dout` in response to `controller_latch` and `controller_clk` from an external poller, such as `nes_interface`. In the laser pinball system it sits between a test or remote source of button state and the controller header. This lets the game, paddles and camera start be driven without a physical pad, and provides a loopback target for verifying `nes_interface`.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous protocol input (≥2).
- `TIMEOUT_CYCLES`, 50000: `clk_50` cycles without a protocol event before an in-progress shift is abandoned (1 ms at 50 MHz).
- `clk_50`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `controller_latch`  in  1  latch from poller, asynchronous; high = load.
- `controller_clk`  in  1  shift clock from poller, asynchronous; idles high.
- `buttons`  in  12  pressed = 1; bit order {R,L,X,A,E,W,S,N,START,SELECT,Y,B}, bit0 = B.
- `controller_dout`  out  1  serial data; active-low (0 = pressed); registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse on completion of a full 16-bit frame.
- `poll_count`  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- **Synchronizers.**
  - `controller_latch` and `controller_clk` each pass through `SYNC_STAGES` FFs, then one edge-detect register.
  - Reset values: latch chain 0; clk chain 1, so no spurious edge comes out of reset.
- **Snapshot.** 16-bit shift register `shreg` holds line levels, loaded as {4'b1111, ~buttons}; `controller_dout` = `shreg[0]`.
- **State machine.**
  - **IDLE.**
    - `shreg` = 16'hFFFF, `controller_dout` = 1.
    - Synchronized latch high → LOAD.
  - **LOAD.**
    - `shreg` reloads from `buttons` every cycle, so `dout` tracks the current B button.
    - Rising clk edges are ignored.
    - Synchronized latch falling edge → SHIFT; `bit_idx` = 0, `timer` = 0.
  - **SHIFT.**
    - On each synchronized rising clk edge: `shreg` ← {1'b1, `shreg[15:1]`}, `bit_idx` += 1, `timer` = 0.
    - When `bit_idx` reaches 16 (16th edge): pulse `frame_done`, `poll_count` += 1, → IDLE.
    - Synchronized latch rising edge → LOAD immediately (abort; no `frame_done`, no count).
    - `timer` reaching `TIMEOUT_CYCLES` → IDLE (no `frame_done`, no count).
- **Data sequence after latch fall.** B, Y, SELECT, START, N, S, W, E, A, X, L, R, then 1,1,1,1 (unused/ID bits). After the frame, `dout` idles at 1.
- **Button changes.** Changes to `buttons` during SHIFT do not affect the frame in flight.
- **Simultaneous events.** If a latch rise and a clk rise are detected in the same cycle in SHIFT, the latch wins (→ LOAD, no shift). A timeout and a clk edge in the same cycle: the edge wins.
- **Frame length.** `bit_idx` is 5 bits, and a frame ends at exactly 16 edges. Extra clk edges in IDLE are ignored, and `dout` stays 1.

## Timing
- **Reset values.** State IDLE, `controller_dout` 1, `busy` 0, `frame_done` 0, `poll_count` 0, `shreg` 16'hFFFF, `timer` 0, `bit_idx` 0.
- **Reset mid-operation.** Asserting reset returns everything to the reset values asynchronously. No partial frame is counted.
- **Latency.** An external latch or clk edge reaches `controller_dout` `SYNC_STAGES` + 2 `clk_50` cycles later (4 cycles = 80 ns at defaults). This is far below the 6 µs protocol half-period, so the poller samples stable data on its next falling clk.
- **`busy`.** Rises 1 cycle after the synchronized latch rise; falls in the cycle state returns to IDLE.
- **`frame_done`.** Asserted for exactly 1 cycle, concurrent with the `poll_count` increment and the transition to IDLE.
- **Input hold.** Latch and clk pulses shorter than 2 `clk_50` cycles may be missed; the protocol guarantees ≥ 6 µs.

## Test plan
- **Reset.** Assert reset mid-shift → `dout` = 1, `busy` = 0, `poll_count` = 0 immediately, without waiting for a `clk_50` edge.
- **B only.** `buttons` = 12'h001; 12 µs latch, then 16 clk pulses of 6 µs/6 µs → `dout` sampled on falling clk reads 0 then fifteen 1s; one `frame_done`; `poll_count` = 1.
- **Mixed pattern.** `buttons` = 12'h108 (A, START); full poll → sampled bits 1,1,1,0,1,1,1,1,0,1,1,1,1,1,1,1.
- **Mid-frame change.** Change `buttons` to 12'hFFF after the 5th clk edge → remaining bits still reflect the original snapshot. The next poll returns bits 0–11 = 0 and bits 12–15 = 1.
- **Abort and timeout.**
  - Latch re-asserted after 7 edges → LOAD; no `frame_done`; `poll_count` unchanged.
  - Latch fall followed by no clk for 1.1 ms → IDLE, `busy` = 0, `dout` = 1.
- **Count wrap.** Preload 65535 completed polls (or force `poll_count` to 16'hFFFF), then one full poll → `poll_count` = 0 with a single `frame_done` pulse. Loopback against `nes_interface` returns the driven `buttons` on all 12 outputs.
